// File: rtl/chip8_pkg.sv
// Shared encodings for the CHIP-8 subroutine call/return controller:
// FSM states, request opcodes, stack commands and the reset PC.
package chip8_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PUSH  = 3'd1,
    POP   = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4,
    FAULT = 3'd5
  } ctrl_state_t;

  localparam logic [1:0] OP_CALL = 2'b01;
  localparam logic [1:0] OP_RET  = 2'b10;

  localparam logic [1:0] STK_NOP  = 2'b00;
  localparam logic [1:0] STK_PUSH = 2'b01;
  localparam logic [1:0] STK_POP  = 2'b10;

  localparam logic [15:0] PC_RESET = 16'h0200;

  // CHIP-8 instructions are two bytes, so a CALL returns to the next one.
  function automatic logic [15:0] ret_addr(input logic [15:0] pc);
    return pc + 16'd2;
  endfunction

endpackage

// File: rtl/chip8_call_ret_ctrl.sv
// CHIP-8 2NNN/00EE sequencer: drives an external return-address stack,
// tracks its fill level and produces the next PC or a fault strobe.
module chip8_call_ret_ctrl
  import chip8_pkg::*;
#(
  parameter int STACK_DEPTH = 16
) (
  input  logic        cpu_clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_pc,
  input  logic [11:0] req_target,
  output logic        req_ready,
  output logic [1:0]  stk_we,
  output logic [15:0] stk_writedata,
  input  logic [15:0] stk_outdata,
  output logic        pc_valid,
  output logic [15:0] pc_out,
  output logic        fault,
  output logic [4:0]  depth
);

  localparam logic [4:0] DEPTH_MAX = 5'(STACK_DEPTH);

  ctrl_state_t state, state_nxt;
  logic [4:0]  depth_q;
  logic [15:0] pc_q;
  logic [15:0] wdata_q;
  logic [11:0] target_q;

  always_ff @(posedge cpu_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    stk_we    = STK_NOP;
    pc_valid  = 1'b0;
    fault     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_op == OP_CALL && depth_q < DEPTH_MAX)
            state_nxt = PUSH;
          else if (req_op == OP_RET && depth_q != 5'd0)
            state_nxt = POP;
          else
            state_nxt = FAULT;
        end
      end
      PUSH: begin
        stk_we    = STK_PUSH;
        state_nxt = DONE;
      end
      POP: begin
        stk_we    = STK_POP;
        state_nxt = WAIT;
      end
      WAIT:  state_nxt = DONE;
      DONE: begin
        pc_valid  = 1'b1;
        state_nxt = IDLE;
      end
      FAULT: begin
        fault     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset masks every strobe so an abandoned operation leaves no trace.
    if (reset) begin
      req_ready = 1'b0;
      stk_we    = STK_NOP;
      pc_valid  = 1'b0;
      fault     = 1'b0;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      depth_q  <= 5'd0;
      pc_q     <= PC_RESET;
      wdata_q  <= 16'h0000;
      target_q <= 12'h000;
    end else begin
      if (state == IDLE && state_nxt == PUSH) begin
        wdata_q  <= ret_addr(req_pc);
        target_q <= req_target;
      end
      case (state)
        PUSH: begin
          depth_q <= depth_q + 5'd1;
          pc_q    <= {4'h0, target_q};
        end
        POP:  depth_q <= depth_q - 5'd1;
        WAIT: pc_q    <= stk_outdata;
        default: ;
      endcase
    end
  end

  assign depth         = depth_q;
  assign pc_out        = pc_q;
  assign stk_writedata = wdata_q;

endmodule

// File: tb/tb_chip8_call_ret_ctrl.sv
// Self-checking bench: transaction-level model of call/return behaviour,
// a simple stack memory for the DUT, directed and randomized traffic.
module tb_chip8_call_ret_ctrl;

  logic        cpu_clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [15:0] req_pc;
  logic [11:0] req_target;
  logic        req_ready;
  logic [1:0]  stk_we;
  logic [15:0] stk_writedata;
  logic [15:0] stk_outdata = 16'h0000;
  logic        pc_valid;
  logic [15:0] pc_out;
  logic        fault;
  logic [4:0]  depth;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  chip8_call_ret_ctrl #(.STACK_DEPTH(16)) dut (
    .cpu_clk(cpu_clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_pc(req_pc), .req_target(req_target), .req_ready(req_ready),
    .stk_we(stk_we), .stk_writedata(stk_writedata), .stk_outdata(stk_outdata),
    .pc_valid(pc_valid), .pc_out(pc_out), .fault(fault), .depth(depth)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Stack memory the DUT talks to; pop data is registered on the pop edge.
  logic [15:0] stk_mem[$];
  always @(posedge cpu_clk) begin
    if (reset) stk_mem.delete();
    else if (stk_we == 2'b01) stk_mem.push_back(stk_writedata);
    else if (stk_we == 2'b10 && stk_mem.size() > 0) stk_outdata <= stk_mem.pop_back();
  end

  typedef struct {
    logic [1:0]  we;
    logic [15:0] wd;
    logic        pcv;
    logic        flt;
    logic [4:0]  d;
    logic [15:0] pc;
  } exp_t;

  exp_t        sched[$];
  logic [15:0] mstack[$];
  int          m_depth = 0;
  logic [15:0] m_pc = 16'h0200;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle reference: an accepted request expands into its cycle-by-cycle outputs.
  always @(negedge cpu_clk) begin
    if (chk_on) begin
      exp_t e;
      logic rdy_exp;
      logic [15:0] top;
      rdy_exp = (sched.size() == 0) && !reset;
      if (sched.size() > 0) e = sched.pop_front();
      else e = '{we: 2'b00, wd: 16'h0, pcv: 1'b0, flt: 1'b0, d: 5'(m_depth), pc: m_pc};
      if (reset) begin
        e.we = 2'b00; e.pcv = 1'b0; e.flt = 1'b0;
      end
      checkOutput("req_ready", {15'h0, req_ready}, {15'h0, rdy_exp});
      checkOutput("stk_we", {14'h0, stk_we}, {14'h0, e.we});
      checkOutput("pc_valid", {15'h0, pc_valid}, {15'h0, e.pcv});
      checkOutput("fault", {15'h0, fault}, {15'h0, e.flt});
      checkOutput("depth", {11'h0, depth}, {11'h0, e.d});
      checkOutput("pc_out", pc_out, e.pc);
      if (e.we == 2'b01) checkOutput("stk_writedata", stk_writedata, e.wd);
      if (reset) begin
        sched.delete();
        mstack.delete();
        m_depth = 0;
        m_pc = 16'h0200;
      end else if (rdy_exp && req_valid) begin
        if (req_op == 2'b01 && m_depth < 16) begin
          sched.push_back('{we: 2'b01, wd: req_pc + 16'd2, pcv: 1'b0, flt: 1'b0, d: 5'(m_depth), pc: m_pc});
          mstack.push_back(req_pc + 16'd2);
          m_depth++;
          m_pc = {4'h0, req_target};
          sched.push_back('{we: 2'b00, wd: 16'h0, pcv: 1'b1, flt: 1'b0, d: 5'(m_depth), pc: m_pc});
        end else if (req_op == 2'b10 && m_depth > 0) begin
          top = mstack.pop_back();
          sched.push_back('{we: 2'b10, wd: 16'h0, pcv: 1'b0, flt: 1'b0, d: 5'(m_depth), pc: m_pc});
          m_depth--;
          sched.push_back('{we: 2'b00, wd: 16'h0, pcv: 1'b0, flt: 1'b0, d: 5'(m_depth), pc: m_pc});
          m_pc = top;
          sched.push_back('{we: 2'b00, wd: 16'h0, pcv: 1'b1, flt: 1'b0, d: 5'(m_depth), pc: m_pc});
        end else begin
          sched.push_back('{we: 2'b00, wd: 16'h0, pcv: 1'b0, flt: 1'b1, d: 5'(m_depth), pc: m_pc});
        end
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [15:0] pc, input logic [11:0] tgt);
    bit took = 1'b0;
    @(posedge cpu_clk); #1;
    req_valid = 1'b1; req_op = op; req_pc = pc; req_target = tgt;
    for (int i = 0; i < 30 && !took; i++) begin
      @(negedge cpu_clk);
      if (req_ready && !reset) took = 1'b1;
    end
    if (!took) begin
      total++; bad++;
      $display("[TB] FAIL accept_timeout: got no acceptance expected acceptance within 30 cycles");
    end
    @(posedge cpu_clk); #1;
    req_valid = 1'b0; req_op = 2'($urandom); req_pc = 16'($urandom); req_target = 12'($urandom);
  endtask

  task automatic waitIdle();
    bool_loop: for (int i = 0; i < 20; i++) begin
      @(negedge cpu_clk);
      if (sched.size() == 0) return;
    end
    total++; bad++;
    $display("[TB] FAIL idle_timeout: got busy expected idle within 20 cycles");
  endtask

  task automatic doReset(input int n);
    @(posedge cpu_clk); #1;
    reset = 1'b1; req_valid = 1'b0;
    repeat (n) @(posedge cpu_clk);
    #1 reset = 1'b0;
  endtask

  logic [11:0] last_tgt;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_pc = 16'h0; req_target = 12'h0;
    @(posedge cpu_clk);
    chk_on = 1'b1;
    repeat (2) @(posedge cpu_clk);
    #1 reset = 1'b0;
    @(negedge cpu_clk);
    checkOutput("reset_depth", {11'h0, depth}, 16'h0000);
    checkOutput("reset_pc", pc_out, 16'h0200);
    checkOutput("reset_ready", {15'h0, req_ready}, 16'h0001);
    checkOutput("reset_wdata", stk_writedata, 16'h0000);

    $display("[TB] basic CALL then RET");
    applyStimulus(2'b01, 16'h0200, 12'h345);
    @(negedge cpu_clk);
    checkOutput("call_we", {14'h0, stk_we}, 16'h0001);
    checkOutput("call_wdata", stk_writedata, 16'h0202);
    @(negedge cpu_clk);
    checkOutput("call_pcv", {15'h0, pc_valid}, 16'h0001);
    checkOutput("call_pc", pc_out, 16'h0345);
    checkOutput("call_depth", {11'h0, depth}, 16'h0001);
    waitIdle();
    applyStimulus(2'b10, 16'h0345, 12'h000);
    @(negedge cpu_clk);
    checkOutput("ret_we_pop", {14'h0, stk_we}, 16'h0002);
    @(negedge cpu_clk);
    checkOutput("ret_we_wait", {14'h0, stk_we}, 16'h0000);
    @(negedge cpu_clk);
    checkOutput("ret_pcv", {15'h0, pc_valid}, 16'h0001);
    checkOutput("ret_pc", pc_out, 16'h0202);
    checkOutput("ret_depth", {11'h0, depth}, 16'h0000);
    waitIdle();

    $display("[TB] overflow");
    last_tgt = 12'h000;
    for (int i = 0; i < 16; i++) begin
      last_tgt = 12'($urandom);
      applyStimulus(2'b01, 16'($urandom), last_tgt);
      waitIdle();
    end
    applyStimulus(2'b01, 16'h0300, 12'hABC);
    @(negedge cpu_clk);
    checkOutput("ovf_fault", {15'h0, fault}, 16'h0001);
    checkOutput("ovf_we", {14'h0, stk_we}, 16'h0000);
    checkOutput("ovf_depth", {11'h0, depth}, 16'h0010);
    checkOutput("ovf_pc", pc_out, {4'h0, last_tgt});
    waitIdle();

    $display("[TB] underflow and illegal op");
    doReset(2);
    applyStimulus(2'b10, 16'h0400, 12'h000);
    @(negedge cpu_clk);
    checkOutput("unf_fault", {15'h0, fault}, 16'h0001);
    checkOutput("unf_we", {14'h0, stk_we}, 16'h0000);
    waitIdle();
    applyStimulus(2'b11, 16'h0400, 12'h123);
    @(negedge cpu_clk);
    checkOutput("ill_fault", {15'h0, fault}, 16'h0001);
    checkOutput("ill_we", {14'h0, stk_we}, 16'h0000);
    waitIdle();

    $display("[TB] reset during pop");
    applyStimulus(2'b01, 16'h0500, 12'h777);
    waitIdle();
    applyStimulus(2'b10, 16'h0777, 12'h000);
    reset = 1'b1;
    @(posedge cpu_clk); #1 reset = 1'b0;
    @(negedge cpu_clk);
    checkOutput("rstpop_ready", {15'h0, req_ready}, 16'h0001);
    checkOutput("rstpop_pc", pc_out, 16'h0200);
    checkOutput("rstpop_depth", {11'h0, depth}, 16'h0000);
    checkOutput("rstpop_pcv", {15'h0, pc_valid}, 16'h0000);

    $display("[TB] held request with changing target");
    for (int i = 0; i < 40; i++) begin
      @(posedge cpu_clk); #1;
      req_valid = 1'b1; req_op = 2'b01;
      req_pc = 16'($urandom); req_target = 12'($urandom);
    end
    @(posedge cpu_clk); #1 req_valid = 1'b0;
    waitIdle();

    $display("[TB] random traffic");
    doReset(1);
    for (int i = 0; i < 600; i++) begin
      @(posedge cpu_clk); #1;
      reset      = ($urandom_range(0, 59) == 0);
      req_valid  = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 9))
        0:       req_op = 2'b00;
        1:       req_op = 2'b11;
        2, 3, 4, 5: req_op = 2'b01;
        default: req_op = 2'b10;
      endcase
      req_pc     = 16'($urandom);
      req_target = 12'($urandom);
    end
    @(posedge cpu_clk); #1;
    reset = 1'b0; req_valid = 1'b0;
    waitIdle();
    repeat (2) @(negedge cpu_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 1000000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
